// File: rtl/apb_initiator.sv
// apb_initiator: APB4 requester, one outstanding transfer, valid/ready command and response channels.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES cycles without pready.
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [2:0]  prot_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        timeout_q;

    logic        accept;
    logic        in_xfer;
    logic        done;
    logic        abort;

    // Both channels transfer on a cycle where valid & ready are high at the rising edge;
    // valid is never withdrawn by this block until that edge.
    assign accept  = cmd_valid && (state == IDLE);
    assign in_xfer = (state == SETUP) || (state == ACCESS);
    assign done    = (state == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES; pready wins a tie.
    assign abort = (state == ACCESS) && !pready && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (state != ACCESS)) begin
            wait_cnt <= '0;
        end else if (!pready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign abort              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (accept) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            strb_q  <= cmd_strb;
            prot_q  <= cmd_prot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (done) begin
            rdata_q   <= write_q ? 32'h0 : prdata;
            err_q     <= pslverr;
            timeout_q <= 1'b0;
        end else if (abort) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = '0;
        pwdata     = '0;
        pstrb      = '0;
        pprot      = '0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                penable = 1'b1;
                if (pready || abort) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Address/data buses carry the registered command only while a transfer is on the bus.
        if (in_xfer) begin
            psel   = 1'b1;
            pwrite = write_q;
            paddr  = addr_q;
            pprot  = prot_q;
            pwdata = write_q ? wdata_q : 32'h0;
            pstrb  = write_q ? strb_q : 4'h0;
        end
    end

    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: directed plan cases plus randomized transfers
// against a transaction-level model (latency arithmetic and an expected-response queue).
module tb_apb_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    // {timeout, err, rdata} of each response still owed by the DUT
    logic [33:0] exp_q[$];

    apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_apb_idle(input string tag);
        check({tag, "_ctl"}, {22'h0, psel, penable, pwrite, pstrb, pprot}, 32'h0);
        check({tag, "_paddr"}, paddr, 32'h0);
        check({tag, "_pwdata"}, pwdata, 32'h0);
    endtask

    task automatic scramble_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    // Entered and left #1 after a rising edge; the first sampled cycle is the accept cycle.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic slverr, input logic [31:0] rdata, input int bp);
        int          acc_cycles;
        logic        timed_out;
        logic [33:0] exp;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
`ifdef APB_TIMEOUT_EN
        timed_out = (waits >= TO);
`else
        timed_out = 1'b0;
`endif
        acc_cycles = timed_out ? TO : waits + 1;
        e_wdata    = wr ? wdata : 32'h0;
        e_strb     = wr ? strb : 4'h0;
        if (timed_out) exp_q.push_back({2'b11, 32'h0});
        else           exp_q.push_back({1'b0, slverr, (wr ? 32'h0 : rdata)});

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_prot  = prot;
        rsp_ready = 1'($urandom);
        @(negedge clk);
        check("accept_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("accept_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_apb_idle("accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;

        @(negedge clk);
        check("setup_ctl", {29'h0, psel, penable, pwrite}, {29'h0, 2'b10, wr});
        check("setup_paddr", paddr, addr);
        check("setup_pwdata", pwdata, e_wdata);
        check("setup_pstrb_pprot", {25'h0, pstrb, pprot}, {25'h0, e_strb, prot});
        check("setup_ready_valid", {30'h0, cmd_ready, rsp_valid}, 32'h0);
        @(posedge clk);

        for (int n = 1; n <= acc_cycles; n++) begin
            #1;
            if (!timed_out && n == acc_cycles) begin
                pready  = 1'b1;
                pslverr = slverr;
                prdata  = rdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            @(negedge clk);
            check("access_ctl", {29'h0, psel, penable, pwrite}, {29'h0, 2'b11, wr});
            check("access_paddr", paddr, addr);
            check("access_pwdata", pwdata, e_wdata);
            check("access_pstrb_pprot", {25'h0, pstrb, pprot}, {25'h0, e_strb, prot});
            check("access_ready_valid", {30'h0, cmd_ready, rsp_valid}, 32'h0);
            @(posedge clk);
        end

        exp = exp_q.pop_front();
        for (int b = 0; b <= bp; b++) begin
            #1;
            rsp_ready = (b == bp);
            pready    = 1'($urandom);
            pslverr   = 1'($urandom);
            prdata    = $urandom;
            @(negedge clk);
            check("resp_valid", {31'h0, rsp_valid}, 32'h1);
            check("resp_rdata", rsp_rdata, exp[31:0]);
            check("resp_err_timeout", {30'h0, rsp_timeout, rsp_err}, {30'h0, exp[33], exp[32]});
            check("resp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check_apb_idle("resp");
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'($urandom);
    endtask

    task automatic reset_mid_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'h0000_00A5;
        cmd_strb  = 4'hF;
        cmd_prot  = 3'b001;
        @(negedge clk);
        check("rst_accept_ready", {31'h0, cmd_ready}, 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_access", {30'h0, psel, penable}, 32'h3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        pready  = 1'b1;
        pslverr = 1'($urandom);
        prdata  = $urandom;
        @(negedge clk);
        check_apb_idle("rst_after");
        check("rst_after_ready_valid", {30'h0, cmd_ready, rsp_valid}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

`ifndef APB_TIMEOUT_EN
    task automatic stall_forever();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0008;
        @(negedge clk);
        check("stall_accept_ready", {31'h0, cmd_ready}, 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("stall_still_access", {29'h0, psel, penable, rsp_valid}, 32'h6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("reset_rsp_flags", {29'h0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check_apb_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_xfer(1'b1, 32'h0000_000C, 32'h0000_0083, 4'hF, 3'b000, 0, 1'b0, 32'hDEAD_BEEF, 0);
        do_xfer(1'b0, 32'h0000_0014, 32'h1234_5678, 4'hF, 3'b000, 3, 1'b0, 32'h0000_0060, 0);
        do_xfer(1'b1, 32'h0000_0004, 32'h0000_0001, 4'h1, 3'b010, 0, 1'b1, 32'h0, 0);
        do_xfer(1'b0, 32'h0000_0018, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h0000_00C3, 5);
        do_xfer(1'b1, 32'h0000_0000, 32'h0000_0041, 4'h3, 3'b100, 0, 1'b0, 32'h0, 0);
`ifdef APB_TIMEOUT_EN
        do_xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000, 20, 1'b0, 32'h0, 1);
        do_xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000, TO - 1, 1'b1, 32'h0000_0077, 0);
`else
        stall_forever();
`endif
        reset_mid_access();

        for (int i = 0; i < 150; i++) begin
            do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom,
                    $urandom_range(0, 3));
        end

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
